// File: rtl/refill_mem_arbiter_pkg.sv
// refill_arb_pkg
// Shared types and constants for the refill memory arbiter.
//   state_t   : controller states (IDLE, REQ, XFER, DONE)
//   BEATS     : words per refill block
//   OFFSET_W  : width of the word offset within a block
//   REQ_I/D   : bit positions of the I-cache and D-cache requesters
package refill_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BEATS    = 4;
  localparam int OFFSET_W = 2;
  localparam int REQ_I    = 0;
  localparam int REQ_D    = 1;

endpackage

// File: rtl/refill_mem_arbiter_if.sv
// refill_mem_arbiter_if
// Bundles the requester, memory and fill-port signals of the refill arbiter.
//   req/addr0/addr1          : refill requests and miss addresses from the caches
//   gnt/done                 : one-hot grant and completion pulse back to the caches
//   mem_rd/mem_addr          : read strobe and block-aligned address to memory
//   mem_ready/mem_block      : memory response pulse and full block data
//   fill_we/fill_offset/data : per-beat line write into the granted cache
// Modports:
//   slave  : the arbiter
//   master : the environment (caches plus memory model)
interface refill_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  import refill_arb_pkg::*;

  logic [1:0]              req;
  logic [ADDR_W-1:0]       addr0;
  logic [ADDR_W-1:0]       addr1;
  logic [1:0]              gnt;
  logic                    mem_rd;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_ready;
  logic [WORD_W*BEATS-1:0] mem_block;
  logic [1:0]              fill_we;
  logic [OFFSET_W-1:0]     fill_offset;
  logic [WORD_W-1:0]       fill_data;
  logic [1:0]              done;

  modport slave (
    input  req, addr0, addr1, mem_ready, mem_block,
    output gnt, mem_rd, mem_addr, fill_we, fill_offset, fill_data, done
  );

  modport master (
    output req, addr0, addr1, mem_ready, mem_block,
    input  gnt, mem_rd, mem_addr, fill_we, fill_offset, fill_data, done
  );

endinterface

// File: rtl/refill_mem_arbiter_rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin picker.
//   req  : request vector, bit REQ_I = I-cache, bit REQ_D = D-cache
//   last : index of the requester served most recently (1 = D-cache)
//   pick : one-hot selection, zero when nothing is requested
module rr_arb2
  import refill_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    pick = req;
    if (req[REQ_I] && req[REQ_D]) begin
      pick = '0;
      if (last) begin
        pick[REQ_I] = 1'b1;
      end else begin
        pick[REQ_D] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/refill_mem_arbiter.sv
// refill_mem_arbiter
// Shares the main-memory read port between the I-cache and D-cache refill
// paths. One requester is granted at a time (round-robin on ties), the memory
// read handshake is run, and the returned 4-word block is streamed back to the
// winning cache one word per cycle with its word offset.
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : refill_mem_arbiter_if.slave, all request, memory and fill signals
// Every output is decoded from registered state, so there is no
// combinational path from any input to any output.
module refill_mem_arbiter
  import refill_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  refill_mem_arbiter_if.slave bus
);

  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BEATS - 1);

  state_t              state;
  state_t              state_next;
  logic [OFFSET_W-1:0] cnt_q;
  logic [1:0]          gnt_q;
  logic                last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   block_buf [BEATS];
  logic [1:0]          pick;
  logic [ADDR_W-1:0]   addr_sel;

  rr_arb2 u_rr_arb2 (
    .req  (bus.req),
    .last (last_q),
    .pick (pick)
  );

  // The picker output is one-hot, so bit REQ_D alone chooses the address.
  assign addr_sel = pick[REQ_D] ? bus.addr1 : bus.addr0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus Moore output decode from registered values only.
  always_comb begin
    state_next      = state;
    bus.gnt         = gnt_q;
    bus.mem_rd      = 1'b0;
    bus.mem_addr    = '0;
    bus.fill_we     = '0;
    bus.fill_offset = '0;
    bus.fill_data   = '0;
    bus.done        = '0;

    case (state)
      IDLE: begin
        if (pick != 2'b00) begin
          state_next = REQ;
        end
      end
      REQ: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ready) begin
          state_next = XFER;
        end
      end
      XFER: begin
        bus.fill_we     = gnt_q;
        bus.fill_offset = cnt_q;
        bus.fill_data   = block_buf[cnt_q];
        if (cnt_q == LAST_BEAT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.done   = gnt_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant, aligned address, beat counter, last-served pointer and block buffer.
  // The address is aligned when it is latched, since the requester may drop
  // req (and stop holding its address) while the read is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      gnt_q  <= '0;
      last_q <= 1'b1;
      addr_q <= '0;
      for (int i = 0; i < BEATS; i++) begin
        block_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          cnt_q <= '0;
          if (pick != 2'b00) begin
            gnt_q  <= pick;
            addr_q <= addr_sel & ~ADDR_W'(3);
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            for (int i = 0; i < BEATS; i++) begin
              block_buf[i] <= bus.mem_block[i*WORD_W +: WORD_W];
            end
          end
        end
        XFER: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            last_q <= gnt_q[REQ_D];
          end
        end
        DONE: begin
          gnt_q <= '0;
        end
        default: begin
          gnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_refill_mem_arbiter.sv
// tb_refill_mem_arbiter
// Scoreboard bench for refill_mem_arbiter: stimulus pushes the expected memory
// request, beats and done pulse into a queue; a negedge monitor pops and
// compares whenever the DUT presents one of those outputs.
module tb_refill_mem_arbiter;

  typedef struct {
    int          kind;   // 0 = mem_rd rise, 1 = fill beat, 2 = done
    logic [1:0]  g;
    logic [31:0] addr;
    logic [1:0]  off;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  ev_t  exp_q [$];
  int   rd_rise [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_rd  = 1'b0;

  logic [127:0] junk = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  refill_mem_arbiter_if bus ();

  refill_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_gnt"},         bus.gnt,         0);
    checkOutput({tag, "_mem_rd"},      bus.mem_rd,      0);
    checkOutput({tag, "_mem_addr"},    bus.mem_addr,    0);
    checkOutput({tag, "_fill_we"},     bus.fill_we,     0);
    checkOutput({tag, "_fill_offset"}, bus.fill_offset, 0);
    checkOutput({tag, "_fill_data"},   bus.fill_data,   0);
    checkOutput({tag, "_done"},        bus.done,        0);
  endtask

  // Queue the full expected response of one transaction for requester g.
  task automatic expectTxn(input int g, input logic [31:0] addr, input logic [127:0] blk, input int beats);
    ev_t e;
    logic [1:0] oh;
    oh = (g == 0) ? 2'b01 : 2'b10;
    e = '{kind: 0, g: oh, addr: addr & ~32'h3, off: 2'd0, data: 32'd0};
    exp_q.push_back(e);
    for (int i = 0; i < beats; i++) begin
      e = '{kind: 1, g: oh, addr: 32'd0, off: 2'(i), data: blk[i*32 +: 32]};
      exp_q.push_back(e);
    end
    if (beats == 4) begin
      e = '{kind: 2, g: oh, addr: 32'd0, off: 2'd0, data: 32'd0};
      exp_q.push_back(e);
    end
  endtask

  task automatic popExpect(input int kind, input string name, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: 0, g: 2'b00, addr: 32'd0, off: 2'd0, data: 32'd0};
    if (exp_q.size() == 0) begin
      reportFail({"unexpected_", name});
    end else begin
      e = exp_q.pop_front();
      checkOutput({name, "_order"}, e.kind, kind);
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: compares every presented output event against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (rst) begin
      if (bus.mem_rd && !prev_rd) begin
        rd_rise.push_back(cyc);
        popExpect(0, "mem_rd", e, ok);
        if (ok) begin
          checkOutput("rd_gnt",   bus.gnt,      e.g);
          checkOutput("mem_addr", bus.mem_addr, e.addr);
        end
      end
      if (bus.fill_we != 2'b00) begin
        popExpect(1, "beat", e, ok);
        if (ok) begin
          checkOutput("fill_we",     bus.fill_we,     e.g);
          checkOutput("fill_offset", bus.fill_offset, e.off);
          checkOutput("fill_data",   bus.fill_data,   e.data);
        end
      end
      if (bus.done != 2'b00) begin
        popExpect(2, "done", e, ok);
        if (ok) begin
          checkOutput("done", bus.done, e.g);
        end
      end
    end
    prev_rd = bus.mem_rd;
  end

  // Memory model: wait for mem_rd, delay, pulse mem_ready with the block.
  task automatic serveMem(input int wait_cyc, input logic [127:0] blk, input bit spur);
    int n;
    n = 0;
    while (!bus.mem_rd && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.mem_rd) begin
      reportFail("mem_rd_timeout");
      return;
    end
    for (int i = 0; i < wait_cyc; i++) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    bus.mem_block = blk;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_block = junk;
    if (spur) begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
    end
  endtask

  // Wait for done[g], report its cycle, then drop req[g] after that edge.
  task automatic waitDone(input int g, output int dc);
    dc = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (bus.done[g]) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      reportFail($sformatf("done%0d_timeout", g));
    end
    @(posedge clk); #1;
    bus.req[g] = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] r);
    bus.req = r;
  endtask

  initial begin
    logic [127:0] blk_a, blk_i, blk_d, blk_z, blk_r, blk_f;
    int dc_i, dc_d, c0, sz, n;

    blk_a = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    blk_i = {32'h1000_0013, 32'h1000_0012, 32'h1000_0011, 32'h1000_0010};
    blk_d = {32'h2000_0023, 32'h2000_0022, 32'h2000_0021, 32'h2000_0020};
    blk_z = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    blk_r = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
    blk_f = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};

    rst           = 1'b0;
    bus.req       = 2'b00;
    bus.addr0     = '0;
    bus.addr1     = '0;
    bus.mem_ready = 1'b0;
    bus.mem_block = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Spurious mem_ready while idle: nothing may start.
    bus.mem_ready = 1'b1;
    bus.mem_block = junk;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_spur_mem_rd", bus.mem_rd, 0);
    checkOutput("idle_spur_gnt",    bus.gnt,    0);

    // Tie after reset: I-cache first, then D-cache two cycles after I's done.
    bus.addr0 = 32'h0000_0200;
    bus.addr1 = 32'h0000_030B;
    expectTxn(0, 32'h0000_0200, blk_i, 4);
    expectTxn(1, 32'h0000_030B, blk_d, 4);
    sz = rd_rise.size();
    applyStimulus(2'b11);
    fork
      begin
        serveMem(1, blk_i, 1'b0);
        serveMem(1, blk_d, 1'b0);
      end
      begin
        waitDone(0, dc_i);
        waitDone(1, dc_d);
      end
    join
    if (rd_rise.size() > sz + 1) begin
      checkOutput("d_grant_gap", rd_rise[sz+1] - dc_i, 2);
    end else begin
      reportFail("d_grant_missing");
    end

    // Single I-cache miss at 0x107, slow memory, spurious mem_ready in XFER.
    bus.addr0 = 32'h0000_0107;
    expectTxn(0, 32'h0000_0107, blk_a, 4);
    applyStimulus(2'b01);
    fork
      serveMem(3, blk_a, 1'b1);
      waitDone(0, dc_i);
    join

    // Second tie: I-cache was served last, so the D-cache wins.
    bus.addr0 = 32'h0000_0A01;
    bus.addr1 = 32'h0000_0B02;
    expectTxn(1, 32'h0000_0B02, blk_d, 4);
    expectTxn(0, 32'h0000_0A01, blk_i, 4);
    applyStimulus(2'b11);
    fork
      begin
        serveMem(0, blk_d, 1'b0);
        serveMem(2, blk_i, 1'b0);
      end
      begin
        waitDone(1, dc_d);
        waitDone(0, dc_i);
      end
    join

    // Zero-wait memory: done exactly 6 cycles after req.
    bus.addr1 = 32'h0000_0FFF;
    expectTxn(1, 32'h0000_0FFF, blk_z, 4);
    applyStimulus(2'b10);
    c0 = cyc;
    fork
      serveMem(0, blk_z, 1'b0);
      waitDone(1, dc_d);
    join
    checkOutput("zero_wait_latency", dc_d - c0, 6);

    // Requester drops req while in REQ; transfer and done still complete.
    bus.addr0 = 32'h0000_0040;
    expectTxn(0, 32'h0000_0040, blk_f, 4);
    applyStimulus(2'b01);
    fork
      serveMem(2, blk_f, 1'b0);
      waitDone(0, dc_i);
      begin
        n = 0;
        while (!bus.mem_rd && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        bus.req[0] = 1'b0;
      end
    join

    // Reset during beat offset 2: outputs clear at once, no done follows.
    bus.addr0 = 32'h0000_1230;
    expectTxn(0, 32'h0000_1230, blk_r, 2);
    applyStimulus(2'b01);
    fork
      serveMem(1, blk_r, 1'b0);
      begin
        n = 0;
        while (!(bus.fill_we != 2'b00 && bus.fill_offset == 2'd2) && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 100) begin
          reportFail("beat2_timeout");
        end
        rst     = 1'b0;
        bus.req = 2'b00;
        #1;
        checkIdleOutputs("mid_reset");
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_pending", exp_q.size(), 0);

    // Fresh D-cache request after the abort completes normally.
    bus.addr1 = 32'h0000_5557;
    expectTxn(1, 32'h0000_5557, blk_d, 4);
    applyStimulus(2'b10);
    fork
      serveMem(1, blk_d, 1'b0);
      waitDone(1, dc_d);
    join

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
